// File: rtl/mips_bridge_pkg.sv
// Shared types and helpers for the MIPS CPU to wait-request bus bridge.
package mips_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    EXEC,
    HALT,
    ERROR
  } bridge_state_e;

  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

  // Reverses byte order: {b0,b1,b2,b3} becomes {b3,b2,b1,b0}.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_bus_bridge_watchdog.sv
// Stall counter for the bus bridge: flags expiry on the stalled cycle that
// brings the consecutive-stall count up to TIMEOUT_CYCLES.
module bridge_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  // Number of stalled cycles already seen in the current transfer.
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = count_en && (count_q == LAST_COUNT);

endmodule

// File: rtl/mips_bus_bridge.sv
// Serialises the MIPS core's instruction fetch and optional data access onto
// one wait-request bus. Optional byte swapping via MIPS_BRIDGE_BYTE_SWAP_EN.
module mips_bus_bridge
  import mips_bridge_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  parameter logic [31:0]  RESET_VECTOR   = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic [31:0] cpu_data_writedata,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  output logic [31:0] cpu_data_readdata,
  input  logic        cpu_active,
  output logic        cpu_clock_enable,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        timeout
);

  bridge_state_e state_q;
  logic [31:0]   instr_q;
  logic [31:0]   data_q;

  logic          rd_req;
  logic          wr_req;
  logic          req_active;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          wd_expired;

`ifdef MIPS_BRIDGE_BYTE_SWAP_EN
  assign rd_word = byte_swap(bus_readdata);
  assign wr_word = byte_swap(cpu_data_writedata);
`else
  assign rd_word = bus_readdata;
  assign wr_word = cpu_data_writedata;
`endif

  // Requests decode straight from state so a load/store completes inside the
  // single DATA cycle; the CPU holds its inputs until the commit strobe, which
  // keeps the request stable across stalls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    req_addr  = RESET_VECTOR;
    req_wdata = '0;
    case (state_q)
      FETCH: begin
        rd_req   = 1'b1;
        req_addr = {cpu_instr_address[31:2], 2'b00};
      end
      DATA: begin
        if (cpu_data_read) begin
          rd_req   = 1'b1;
          req_addr = {cpu_data_address[31:2], 2'b00};
        end else if (cpu_data_write) begin
          wr_req    = 1'b1;
          req_addr  = {cpu_data_address[31:2], 2'b00};
          req_wdata = wr_word;
        end
      end
      default: ;
    endcase
  end

  assign req_active = rd_req | wr_req;

  bridge_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (req_active & bus_waitrequest),
    .clear    (~req_active | ~bus_waitrequest),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (wd_expired) begin
            state_q <= ERROR;
          end else if (!bus_waitrequest) begin
            instr_q <= rd_word;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (wd_expired) begin
            state_q <= ERROR;
          end else if (!req_active) begin
            state_q <= EXEC;
          end else if (!bus_waitrequest) begin
            if (rd_req) data_q <= rd_word;
            state_q <= EXEC;
          end
        end
        EXEC:    state_q <= cpu_active ? FETCH : HALT;
        default: state_q <= state_q;
      endcase
    end
  end

  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = data_q;
  assign cpu_clock_enable   = (state_q == EXEC);
  assign timeout            = (state_q == ERROR);
  assign bus_address        = req_addr;
  assign bus_read           = rd_req;
  assign bus_write          = wr_req;
  assign bus_writedata      = req_wdata;
  assign bus_byteenable     = req_active ? BYTEEN_WORD : 4'b0000;

endmodule
